// File: rtl/aes_round_ctrl.sv
// AES round-key sequencer: latches the cipher key for an external expansion block and walks the
// expanded round keys out over a valid/ready port. Define AES_KEY_CACHE_EN to skip LOAD on repeated keys.
module aes_round_ctrl #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [32*Nk-1:0]        key,
    input  logic                    decrypt,
    output logic [32*Nk-1:0]        exp_key,
    input  logic [128*(Nr+1)-1:0]   exp_words,
    output logic [127:0]            rk,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [3:0]              round,
    output logic                    first_round,
    output logic                    last_round,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              fsm_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] LAST_RND = 4'(Nr);

    logic [1:0]   state;
    logic         dec_q;
    logic         handshake;
    logic         skip_load;
    logic [3:0]   start_rnd;
    logic [3:0]   end_rnd;
    logic [127:0] rk_tab [0:Nr];

    for (genvar i = 0; i <= Nr; i++) begin : g_rk_tab
        assign rk_tab[i] = exp_words[128*(Nr+1)-1-128*i -: 128];
    end

`ifdef AES_KEY_CACHE_EN
    // Set once a pass has fully completed; exp_key then still holds a settled expansion.
    logic cache_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_valid <= 1'b0;
        end else if (state == S_DONE) begin
            cache_valid <= 1'b1;
        end
    end

    assign skip_load = cache_valid && (key == exp_key);
`else
    assign skip_load = 1'b0;
`endif

    assign start_rnd = dec_q ? LAST_RND : 4'd0;
    assign end_rnd   = dec_q ? 4'd0 : LAST_RND;

    // Handshake: a round key transfers in any cycle where rk_valid and rk_ready are both high;
    // while rk_valid is high and rk_ready is low, rk and round hold unchanged.
    assign rk_valid  = (state == S_RUN);
    assign handshake = rk_valid & rk_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            exp_key <= '0;
            dec_q   <= 1'b0;
            round   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_key <= key;
                        dec_q   <= decrypt;
                        round   <= decrypt ? LAST_RND : 4'd0;
                        state   <= skip_load ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    round <= start_rnd;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (handshake) begin
                        if (round == end_rnd) begin
                            state <= S_DONE;
                        end else begin
                            round <= dec_q ? round - 4'd1 : round + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // rk is forced to zero outside RUN so that reset clears it immediately.
    assign rk          = rk_valid ? rk_tab[round] : '0;
    assign first_round = rk_valid && (round == start_rnd);
    assign last_round  = rk_valid && (round == end_rnd);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign fsm_state   = state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: an AES key-schedule model stands in for the expansion block
// and supplies the expected round-key sequence for each pass.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         start0, dec0, rk_ready0;
  logic [127:0] key0, exp_key0, rk0;
  logic [1919:0] full0;
  logic [1407:0] exp_words0;
  logic         rk_valid0, first0, last0, busy0, done0;
  logic [3:0]   round0;
  logic [1:0]   st0;

  logic         start1, dec1, rk_ready1;
  logic [255:0] key1, exp_key1;
  logic [1919:0] exp_words1;
  logic [127:0] rk1;
  logic         rk_valid1, first1, last1, busy1, done1;
  logic [3:0]   round1;
  logic [1:0]   st1;

  int n_cmp = 0;
  int n_err = 0;

  bit           cache_ok;
  logic [127:0] cache_key;

`ifdef AES_KEY_CACHE_EN
  localparam int HIT_DONE = 12;
`else
  localparam int HIT_DONE = 13;
`endif

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK14  = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_round_ctrl #(.Nk(4), .Nr(10)) u0 (
    .clk(clk), .reset(reset), .start(start0), .key(key0), .decrypt(dec0),
    .exp_key(exp_key0), .exp_words(exp_words0), .rk(rk0), .rk_valid(rk_valid0),
    .rk_ready(rk_ready0), .round(round0), .first_round(first0), .last_round(last0),
    .busy(busy0), .done(done0), .fsm_state(st0)
  );

  aes_round_ctrl #(.Nk(8), .Nr(14)) u1 (
    .clk(clk), .reset(reset), .start(start1), .key(key1), .decrypt(dec1),
    .exp_key(exp_key1), .exp_words(exp_words1), .rk(rk1), .rk_valid(rk_valid1),
    .rk_ready(rk_ready1), .round(round1), .first_round(first1), .last_round(last1),
    .busy(busy1), .done(done1), .fsm_state(st1)
  );

  // ---------------- AES key schedule model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round i key lands at [1919-128*i -: 128]; the key occupies the top 32*nk bits of k.
  function automatic logic [1919:0] expand_key(input logic [255:0] k, input int nk, input int nr);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] f;
    f = '0;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = k[255 - 32 * i -: 32];
      end else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i - nk] ^ t;
      end
      f[1919 - 32 * i -: 32] = w[i];
    end
    return f;
  endfunction

  always_comb full0 = expand_key({exp_key0, 128'h0}, 4, 10);
  assign exp_words0 = full0[1919:512];
  always_comb exp_words1 = expand_key(exp_key1, 8, 14);

  // ---------------- driver / scoreboard for the Nk=4 instance ----------------
  task automatic run_pass(input logic [127:0] k, input logic d, input int mode,
                          output int done_cyc, output logic [127:0] first_rk,
                          output logic [127:0] last_rk, output int hs, output int done_cnt);
    logic [1919:0] f;
    logic [127:0]  exp_q[$];
    int            rnd_q[$];
    int            lat, c, ldone;
    bit            fin, exp_valid, exp_done;
    f = expand_key({k, 128'h0}, 4, 10);
    for (int n = 0; n <= 10; n++) begin
      int r;
      r = d ? 10 - n : n;
      rnd_q.push_back(r);
      exp_q.push_back(f[1919 - 128 * r -: 128]);
    end
    lat = 2;
`ifdef AES_KEY_CACHE_EN
    if (cache_ok && k == cache_key) lat = 1;
`endif
    done_cyc = -1; hs = 0; done_cnt = 0; fin = 0; c = 0; ldone = -1;
    first_rk = '0; last_rk = '0;
    @(posedge clk); #1;
    start0 = 1'b1; key0 = k; dec0 = d; rk_ready0 = 1'b1;
    while (!fin && c < 60) begin
      @(negedge clk);
      exp_valid = (c >= lat) && (hs < 11);
      exp_done  = (c == ldone);
      n_cmp++;
      if (rk_valid0 !== exp_valid) begin
        n_err++; $display("FAIL rk_valid c=%0d got=%b exp=%b", c, rk_valid0, exp_valid);
      end
      n_cmp++;
      if (busy0 !== (c >= 1)) begin
        n_err++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy0, (c >= 1));
      end
      n_cmp++;
      if (done0 !== exp_done) begin
        n_err++; $display("FAIL done c=%0d got=%b exp=%b", c, done0, exp_done);
      end
      if (c >= 1) begin
        n_cmp++;
        if (exp_key0 !== k) begin
          n_err++; $display("FAIL exp_key c=%0d got=%h exp=%h", c, exp_key0, k);
        end
      end
      n_cmp++;
      if (rk0 !== (exp_valid ? exp_q[0] : 128'h0)) begin
        n_err++; $display("FAIL rk c=%0d got=%h exp=%h", c, rk0, exp_valid ? exp_q[0] : 128'h0);
      end
      n_cmp++;
      if (first0 !== (exp_valid && hs == 0)) begin
        n_err++; $display("FAIL first_round c=%0d got=%b exp=%b", c, first0, (exp_valid && hs == 0));
      end
      n_cmp++;
      if (last0 !== (exp_valid && hs == 10)) begin
        n_err++; $display("FAIL last_round c=%0d got=%b exp=%b", c, last0, (exp_valid && hs == 10));
      end
      if (exp_valid) begin
        n_cmp++;
        if (round0 !== 4'(rnd_q[0])) begin
          n_err++; $display("FAIL round c=%0d got=%0d exp=%0d", c, round0, rnd_q[0]);
        end
      end
      n_cmp++;
      if (round0 > 4'd10) begin
        n_err++; $display("FAIL round_range c=%0d got=%0d exp<=10", c, round0);
      end
      if (exp_valid && rk_ready0) begin
        if (hs == 0) first_rk = rk0;
        if (hs == 10) last_rk = rk0;
        void'(exp_q.pop_front());
        void'(rnd_q.pop_front());
        hs++;
        if (hs == 11) ldone = c + 1;
      end
      if (done0) done_cnt++;
      if (exp_done) begin
        fin = 1; done_cyc = c;
      end
      if (!fin) begin
        @(posedge clk); #1;
        c++;
        // start is raised in the DONE cycle on purpose: it must be ignored there.
        start0 = (hs == 11) ? 1'b1 : 1'($urandom_range(0, 1));
        key0 = {$urandom, $urandom, $urandom, $urandom};
        dec0 = 1'($urandom_range(0, 1));
        case (mode)
          0: rk_ready0 = 1'b1;
          1: rk_ready0 = (c < lat) || ((c - lat) % 3 == 0);
          default: rk_ready0 = 1'($urandom_range(0, 1));
        endcase
      end
    end
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL pass_timeout got=%0d handshakes exp=11 and done", hs);
    end else begin
      cache_ok = 1; cache_key = k;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      key0 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_cmp++;
      if (busy0 !== 1'b0 || rk_valid0 !== 1'b0 || done0 !== 1'b0) begin
        n_err++; $display("FAIL idle got busy=%b valid=%b done=%b exp=0,0,0", busy0, rk_valid0, done0);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_key(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_key("reset_rk", rk0, 128'h0);
    check_key("reset_exp_key", exp_key0, 128'h0);
    check_int("reset_round", int'(round0), 0);
    check_int("reset_flags", int'({rk_valid0, busy0, done0, first0, last0}), 0);
    check_int("reset_u1_flags", int'({rk_valid1, busy1, done1, first1, last1}), 0);
    check_key("reset_u1_rk", rk1, 128'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cache_ok = 0;
    @(negedge clk);
    check_int("post_reset_busy", int'(busy0), 0);
  endtask

  task automatic test_vectors();
    int dc, hs, dn;
    logic [127:0] fr, lr;
    run_pass(K128, 1'b0, 0, dc, fr, lr, hs, dn);
    check_int("enc_done_cycle", dc, 13);
    check_key("enc_first_rk", fr, K128);
    check_key("enc_last_rk", lr, RK10);
    check_int("enc_handshakes", hs, 11);
    check_int("enc_done_pulses", dn, 1);
    idle_check(1);
    run_pass(K128, 1'b1, 0, dc, fr, lr, hs, dn);
    check_int("dec_done_cycle", dc, HIT_DONE);
    check_key("dec_first_rk", fr, RK10);
    check_key("dec_last_rk", lr, K128);
    check_int("dec_done_pulses", dn, 1);
    idle_check(1);
  endtask

  task automatic test_ready_toggle();
    int dc, hs, dn;
    logic [127:0] fr, lr, k;
    k = {$urandom, $urandom, $urandom, $urandom};
    run_pass(k, 1'b0, 1, dc, fr, lr, hs, dn);
    check_int("toggle_handshakes", hs, 11);
    check_int("toggle_done_pulses", dn, 1);
    idle_check(2);
  endtask

  task automatic test_back_to_back();
    int dc, hs, dn;
    logic [127:0] fr, lr, ka, kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    run_pass(ka, 1'b0, 0, dc, fr, lr, hs, dn);
    check_int("b2b_first_done", dc, 13);
    run_pass(ka, 1'b1, 0, dc, fr, lr, hs, dn);
    check_int("b2b_same_key_done", dc, HIT_DONE);
    run_pass(kb, 1'b0, 0, dc, fr, lr, hs, dn);
    check_int("b2b_new_key_done", dc, 13);
    idle_check(1);
  endtask

  task automatic test_random();
    int dc, hs, dn;
    logic [127:0] fr, lr, k;
    k = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) k = {$urandom, $urandom, $urandom, $urandom};
      run_pass(k, 1'($urandom_range(0, 1)), 2, dc, fr, lr, hs, dn);
      check_int("rand_handshakes", hs, 11);
      check_int("rand_done_pulses", dn, 1);
      if ($urandom_range(0, 1) == 1) idle_check(1);
    end
    idle_check(1);
  endtask

  task automatic test_reset_mid_pass();
    int dc, hs, dn;
    bit found;
    logic [127:0] fr, lr, k;
    k = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start0 = 1'b1; key0 = k; dec0 = 1'b0; rk_ready0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (rk_valid0 && round0 == 4'd5) found = 1;
    end
    check_int("mid_reach_round5", int'(found), 1);
    #1 reset = 1'b1;
    #1;
    cache_ok = 0;
    check_key("mid_rst_rk", rk0, 128'h0);
    check_key("mid_rst_exp_key", exp_key0, 128'h0);
    check_int("mid_rst_round", int'(round0), 0);
    check_int("mid_rst_flags", int'({rk_valid0, busy0, done0, first0, last0}), 0);
    repeat (2) begin
      @(negedge clk);
      check_int("mid_rst_no_done", int'({done0, busy0}), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_pass(k, 1'b0, 0, dc, fr, lr, hs, dn);
    check_int("mid_rerun_done_cycle", dc, 13);
    check_int("mid_rerun_handshakes", hs, 11);
    check_int("mid_rerun_done_pulses", dn, 1);
    idle_check(1);
  endtask

  task automatic test_aes256();
    logic [1919:0] f;
    logic [127:0]  last;
    int            hs, dc;
    f = expand_key(K256, 8, 14);
    hs = 0; dc = -1; last = '0;
    @(posedge clk); #1;
    start1 = 1'b1; key1 = K256; dec1 = 1'b0; rk_ready1 = 1'b1;
    for (int c = 0; c < 40 && dc < 0; c++) begin
      @(negedge clk);
      if (rk_valid1 && hs <= 14) begin
        check_int("a256_round", int'(round1), hs);
        check_key("a256_rk", rk1, f[1919 - 128 * hs -: 128]);
        if (hs == 14) last = rk1;
        hs++;
      end
      if (done1) dc = c;
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    check_int("a256_done_cycle", dc, 17);
    check_key("a256_last_rk", last, RK14);
    check_int("a256_handshakes", hs, 15);
  endtask

  initial begin
    start0 = 0; key0 = '0; dec0 = 0; rk_ready0 = 0;
    start1 = 0; key1 = '0; dec1 = 0; rk_ready1 = 0;
    reset = 1'b1; cache_ok = 0; cache_key = '0;
    test_reset();
    test_vectors();
    test_ready_toggle();
    test_back_to_back();
    test_random();
    test_reset_mid_pass();
    test_aes256();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
